mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
E-stage multiply/divide unit of the P7 pipeline. It is the producer side of the busy/start handshake that the hazard unit consumes. It executes mult/multu/div/divu over multiple cycles and holds the HI/LO architectural registers. It serves mthi/mtlo/mfhi/mflo, and lets CP0 cancel an instruction that has not yet started.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  E-stage instruction is mult/multu/div/divu; feeds hazard unit as startmd_E
md_op  in  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
src_a  in  32  forwarded rs value in E
src_b  in  32  forwarded rt value in E
req  in  1  exception/interrupt taken this cycle; cancels any E-stage start or mthi/mtlo
busy  out  1  operation in progress; feeds hazard unit as busy_E
hi  out  32  architectural HI
lo  out  32  architectural LO
md_out  out  32  combinational read: hi when md_op=MFHI, lo when md_op=MFLO, else 0

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, shadow registers=0. A reset mid-operation abandons the operation; HI/LO stay 0.
- Accept condition: start=1 && req=0 && busy=0 && md_op in {MULT,MULTU,DIV,DIVU}.
- On the accepting edge:
  - Compute the result from src_a/src_b into shadow registers hi_n/lo_n.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy rises the next cycle.
- busy=1 for exactly N cycles after the accepting edge.
- The edge that ends the Nth busy cycle copies hi_n/lo_n into hi/lo, sets busy=0 and counter=0.
  - MFHI issued in the cycle after busy falls reads the new value.
- State machine: IDLE -> (accept) -> RUN(counter N..1) -> IDLE. No other states.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: the same product, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0: the operation still runs for DIV_CYCLES with busy; hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO (req=0, busy=0): write hi/lo from src_a at the next edge. busy is not asserted.
- Any op while busy=1 (start, MTHI/MTLO): ignored. The hazard unit is responsible for preventing this; the block must not corrupt the in-flight result.
- req=1 in a cycle with start or MTHI/MTLO: nothing is accepted and hi/lo are untouched.
- req does not abort an already-running operation. That operation belongs to an older, committed instruction and completes normally.
- md_out is purely combinational and is not stalled by busy. The hazard unit guarantees MFHI/MFLO never sit in E while busy.

Decomposition:
- constant.v (shared) adds the md_op encodings MD_NONE..MD_MFLO as `define.
- Single module; no sub-module. The multiply and divide use behavioural * / % operators on $signed/unsigned operands into the shadow registers.

Test Plan:
1. mult with src_a=0xFFFFFFFE (-2), src_b=3 -> busy high cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. divu 100/7 -> busy for exactly 10 cycles; then lo=14, hi=2. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. div by 0 with hi=0x11, lo=0x22 preset via mthi/mtlo -> busy for 10 cycles, hi/lo still 0x11/0x22 at completion.
4. start=1 and req=1 together (mult 5*5) -> busy stays 0, hi/lo unchanged. mtlo 0xAB with req=1 -> lo unchanged.
5. mult in flight, then reset_n pulsed low at busy cycle 3 -> busy, hi and lo all 0 immediately (asynchronously), with no later update.
6. multu 0xFFFFFFFF*0xFFFFFFFF, then a second start and an mthi issued while busy -> both ignored; final hi=0xFFFFFFFE, lo=0x00000001. mfhi after completion -> md_out=0xFFFFFFFE.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// controller states, and the arithmetic kernel that fills the shadow registers.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // Result destined for HI/LO; wr=0 means "leave HI/LO unchanged at completion".
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_result_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  function automatic logic is_md_start(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // Full 64-bit product or quotient/remainder for one operation.
  function automatic md_result_t md_compute(input md_op_e op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t  res;
    logic [63:0] prod;
    logic [31:0] b_safe;
    res    = '0;
    prod   = '0;
    // Divide by zero never commits, so any non-zero stand-in keeps the
    // operators free of X without affecting the visible result.
    b_safe = (b == 32'd0) ? 32'd1 : b;
    case (op)
      MD_MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_DIV: begin
        if (a == INT_MIN && b == NEG_ONE) begin
          // The one signed overflow case: quotient wraps, remainder is zero.
          res.lo = INT_MIN;
          res.hi = 32'd0;
        end else begin
          res.lo = $signed(a) / $signed(b_safe);
          res.hi = $signed(a) % $signed(b_safe);
        end
        res.wr = (b != 32'd0);
      end
      MD_DIVU: begin
        res.lo = a / b_safe;
        res.hi = a % b_safe;
        res.wr = (b != 32'd0);
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit. Holds architectural HI/LO, runs mult/div for a
// fixed number of busy cycles, and serves mthi/mtlo/mfhi/mflo.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_n_q, hi_n_d;
  logic [31:0] lo_n_q, lo_n_d;
  logic        wr_n_q, wr_n_d;

  md_op_e      op;
  logic        accept;
  md_result_t  res;

  assign op     = md_op_e'(md_op);
  assign accept = start && !req && (state_q == S_IDLE) && is_md_start(op);
  assign res    = md_compute(op, src_a, src_b);

  // Next-state logic: accept a new operation, count down, commit, or serve mthi/mtlo.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned -- that is what keeps this block from inferring latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_n_d  = wr_n_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hi_n_d  = res.hi;
          lo_n_d  = res.lo;
          wr_n_d  = res.wr;
          cnt_d   = is_mult(op) ? MULT_CNT : DIV_CNT;
          state_d = S_RUN;
        end else if (!req && op == MD_MTHI) begin
          hi_d = src_a;
        end else if (!req && op == MD_MTLO) begin
          lo_d = src_a;
        end
      end
      S_RUN: begin
        // Requests while running are ignored; req cannot abort a committed op.
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (wr_n_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and data registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
      wr_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_n_q  <= wr_n_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Combinational HI/LO read port; not gated by busy.
  always_comb begin
    md_out = 32'd0;
    if (op == MD_MFHI)      md_out = hi_q;
    else if (op == MD_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus random traffic,
// compared every cycle against a behavioural HI/LO model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model: architectural HI/LO plus a pending result and cycles left.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
  bit          p_valid = 1'b0;
  int          m_left = 0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .req(req),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic done in 64-bit integers from the ISA definitions.
  task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, q, r;
    longint unsigned up;
    p_valid = 1'b1;
    case (op)
      MD_MULT: begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        p_hi = 32'(sp >>> 32); p_lo = 32'(sp);
      end
      MD_MULTU: begin
        up = longint'(a) * longint'(b);
        p_hi = 32'(up >> 32); p_lo = 32'(up);
      end
      MD_DIV: begin
        if (b == 0) p_valid = 1'b0;
        else begin
          q = longint'(signed'(a)) / longint'(signed'(b));
          r = longint'(signed'(a)) % longint'(signed'(b));
          p_lo = 32'(q); p_hi = 32'(r);
        end
      end
      default: begin
        if (b == 0) p_valid = 1'b0;
        else begin
          q = longint'(a) / longint'(b);
          r = longint'(a) % longint'(b);
          p_lo = 32'(q); p_hi = 32'(r);
        end
      end
    endcase
  endtask

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic cycle(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    bit was_busy;
    start = s; md_op = op; src_a = a; src_b = b; req = r;
    was_busy = (m_left > 0);
    @(posedge clk);
    if (was_busy) begin
      m_left--;
      if (m_left == 0 && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (s && !r && op >= MD_MULT && op <= MD_DIVU) begin
      model_compute(op, a, b);
      m_left = (op <= MD_MULTU) ? MC : DC;
    end else if (!r && op == MD_MTHI) m_hi = a;
    else if (!r && op == MD_MTLO) m_lo = a;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("md_out", md_out, (md_op == MD_MFHI) ? m_hi : (md_op == MD_MFLO) ? m_lo : 32'd0);
    end
  end

  initial begin
    int    busy_cnt;
    logic [3:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 1: mult -2*3, busy exactly MC cycles
    cycle(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_cnt++;
      idle(1);
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'd5);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFFA);

    // 2: divu 100/7, div -7/2, div INT_MIN/-1
    cycle(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      idle(1);
    end
    check("t2_busy_cycles", 32'(busy_cnt), 32'd10);
    check("t2_divu_lo", lo, 32'd14);
    check("t2_divu_hi", hi, 32'd2);
    cycle(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC);
    check("t2_div_lo", lo, 32'hFFFF_FFFD);
    check("t2_div_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC);
    check("t2_ovf_lo", lo, 32'h8000_0000);
    check("t2_ovf_hi", hi, 32'd0);

    // 3: divide by zero leaves preset HI/LO
    cycle(1'b0, MD_MTHI, 32'h11, 32'd0, 1'b0);
    cycle(1'b0, MD_MTLO, 32'h22, 32'd0, 1'b0);
    cycle(1'b1, MD_DIV, 32'd55, 32'd0, 1'b0);
    idle(DC - 1);
    check("t3_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    check("t3_busy_done", {31'd0, busy}, 32'd0);
    check("t3_hi", hi, 32'h11);
    check("t3_lo", lo, 32'h22);

    // 4: req cancels start and mtlo
    cycle(1'b1, MD_MULT, 32'd5, 32'd5, 1'b1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    idle(MC + 1);
    cycle(1'b0, MD_MTLO, 32'hAB, 32'd0, 1'b1);
    check("t4_hi", hi, 32'h11);
    check("t4_lo", lo, 32'h22);

    // 6: multu max*max with a start and mthi issued while busy
    cycle(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, MD_MULT, 32'd3, 32'd3, 1'b0);
    cycle(1'b0, MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    idle(MC + 2);
    check("t6_hi", hi, 32'hFFFF_FFFE);
    check("t6_lo", lo, 32'h0000_0001);
    md_op = MD_MFHI;
    #1;
    check("t6_mfhi", md_out, 32'hFFFF_FFFE);
    md_op = MD_MFLO;
    #1;
    check("t6_mflo", md_out, 32'h0000_0001);
    md_op = MD_NONE;

    // 5: async reset during busy cycle 3
    cycle(1'b1, MD_MULT, 32'd7, 32'd9, 1'b0);
    idle(2);
    reset_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; p_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    idle(MC + 2);
    check("t5_no_update_hi", hi, 32'd0);
    check("t5_no_update_lo", lo, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 8));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      cycle(1'($urandom_range(0, 1)), op, a, b, ($urandom_range(0, 7) == 0));
    end
    idle(DC + 1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
